// File: rtl/bram_dwc_down.sv
// Wide-to-narrow BRAM width converter: one wide access becomes RATIO narrow beats, read data gathered.
// Optional BRAM_DWC_DOWN_WRSKIP_EN: write beats whose byte-enable slice is all-zero are not issued.
module bram_dwc_down #(
  parameter int unsigned WIDE_DATA_BITW   = 64,
  parameter int unsigned NARROW_DATA_BITW = 32,
  parameter int unsigned ADDR_BITW        = 32
) (
  input  logic                          Clk_C,
  input  logic                          Rst_RBI,
  input  logic                          Req_SI,
  output logic                          Gnt_SO,
  input  logic [ADDR_BITW-1:0]          Addr_SI,
  input  logic [WIDE_DATA_BITW/8-1:0]   WrEn_SI,
  input  logic [WIDE_DATA_BITW-1:0]     Wr_DI,
  output logic                          RspValid_SO,
  output logic [WIDE_DATA_BITW-1:0]     Rd_DO,
  output logic                          En_SO,
  output logic [ADDR_BITW-1:0]          Addr_SO,
  output logic [NARROW_DATA_BITW/8-1:0] WrEn_SO,
  output logic [NARROW_DATA_BITW-1:0]   Wr_DO,
  input  logic [NARROW_DATA_BITW-1:0]   Rd_DI
);
  localparam int unsigned RATIO  = WIDE_DATA_BITW / NARROW_DATA_BITW;
  localparam int unsigned WB     = WIDE_DATA_BITW / 8;
  localparam int unsigned NB     = NARROW_DATA_BITW / 8;
  localparam int unsigned KW     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned LOG_WB = $clog2(WB);
  localparam int unsigned LOG_NB = $clog2(NB);
  localparam logic [ADDR_BITW-1:0] BASE_MASK =
    ~((ADDR_BITW'(1) << LOG_WB) - ADDR_BITW'(1));

  if (WIDE_DATA_BITW < NARROW_DATA_BITW || (NARROW_DATA_BITW % 8) != 0 ||
      (WIDE_DATA_BITW % NARROW_DATA_BITW) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_param_chk
    $fatal(1, "bram_dwc_down: illegal data width parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_LAST, S_RESP} state_e;
  typedef logic [RATIO-1:0][NB-1:0]               wren_t;
  typedef logic [RATIO-1:0][NARROW_DATA_BITW-1:0] data_t;

  state_e                    state_q, state_d;
  logic [ADDR_BITW-1:0]      addr_q, addr_d;
  wren_t                     wren_q, wren_d;
  data_t                     wdat_q, wdat_d;
  data_t                     gath_q, gath_d;
  logic [WIDE_DATA_BITW-1:0] rd_q, rd_d;
  logic [KW-1:0]             k_q, k_d;
  logic [KW-1:0]             pk_q, pk_d;
  logic                      cap_q, cap_d;

  logic [RATIO-1:0] act_in, act_cur;
  logic             rd_cap;
  logic [KW:0]      nxt;

  // Lowest active slice at or above 'from'; MSB flags that one exists.
  function automatic logic [KW:0] find_next(input logic [RATIO-1:0] act, input int from);
    logic [KW:0] r;
    r = '0;
    for (int j = int'(RATIO) - 1; j >= 0; j--) begin
      if (j >= from && act[j]) r = {1'b1, KW'(j)};
    end
    return r;
  endfunction

  always_comb begin
    act_in  = '1;
    act_cur = '1;
    rd_cap  = 1'b1;
`ifdef BRAM_DWC_DOWN_WRSKIP_EN
    // Writes gather nothing, so Rd_DO keeps the last read word.
    rd_cap = ~|wren_q;
    for (int j = 0; j < int'(RATIO); j++) begin
      act_in[j]  = ~|WrEn_SI | (|WrEn_SI[j*NB +: NB]);
      act_cur[j] = rd_cap | (|wren_q[j]);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wren_d      = wren_q;
    wdat_d      = wdat_q;
    gath_d      = gath_q;
    rd_d        = rd_q;
    k_d         = k_q;
    pk_d        = pk_q;
    cap_d       = 1'b0;
    nxt         = '0;
    Gnt_SO      = 1'b0;
    RspValid_SO = 1'b0;
    En_SO       = 1'b0;
    Addr_SO     = '0;
    WrEn_SO     = '0;
    Wr_DO       = '0;

    // BRAM data arrives the cycle after its beat.
    if (cap_q) gath_d[pk_q] = Rd_DI;

    case (state_q)
      S_IDLE, S_RESP: begin
        Gnt_SO      = 1'b1;
        RspValid_SO = (state_q == S_RESP);
        if (Req_SI) begin
          addr_d  = Addr_SI & BASE_MASK;
          wren_d  = WrEn_SI;
          wdat_d  = Wr_DI;
          nxt     = find_next(act_in, 0);
          k_d     = nxt[KW-1:0];
          state_d = S_BEAT;
        end else if (state_q == S_RESP) begin
          state_d = S_IDLE;
        end
      end
      S_BEAT: begin
        En_SO   = 1'b1;
        Addr_SO = addr_q | (ADDR_BITW'(k_q) << LOG_NB);
        WrEn_SO = wren_q[k_q];
        Wr_DO   = wdat_q[k_q];
        pk_d    = k_q;
        cap_d   = rd_cap;
        nxt     = find_next(act_cur, int'(k_q) + 1);
        if (nxt[KW]) k_d = nxt[KW-1:0];
        else         state_d = S_LAST;
      end
      S_LAST: begin
        if (cap_q) rd_d = gath_d;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_C or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wren_q  <= '0;
      wdat_q  <= '0;
      gath_q  <= '0;
      rd_q    <= '0;
      k_q     <= '0;
      pk_q    <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdat_q  <= wdat_d;
      gath_q  <= gath_d;
      rd_q    <= rd_d;
      k_q     <= k_d;
      pk_q    <= pk_d;
      cap_q   <= cap_d;
    end
  end

  assign Rd_DO = rd_q;

endmodule

// File: tb/tb_bram_dwc_down.sv
// Bench for bram_dwc_down (64->32): vector table + response scoreboard, BRAM model, reset and back-to-back cases.
module tb_bram_dwc_down;
`ifdef BRAM_DWC_DOWN_WRSKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic [31:0] addr  = '0;
  logic [7:0]  we    = '0;
  logic [63:0] wd    = '0;
  logic        gnt, rsp, en;
  logic [63:0] rd;
  logic [31:0] baddr, bwd;
  logic [3:0]  bwe;
  logic [31:0] brd = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bram_dwc_down dut (
    .Clk_C(clk), .Rst_RBI(rst_n), .Req_SI(req), .Gnt_SO(gnt), .Addr_SI(addr),
    .WrEn_SI(we), .Wr_DI(wd), .RspValid_SO(rsp), .Rd_DO(rd), .En_SO(en),
    .Addr_SO(baddr), .WrEn_SO(bwe), .Wr_DO(bwd), .Rd_DI(brd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-first narrow BRAM, 1-cycle read latency.
  logic [31:0] mem [64] = '{default: '0};
  always @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++)
        if (bwe[b]) mem[baddr[7:2]][8*b +: 8] <= bwd[8*b +: 8];
      brd <= mem[baddr[7:2]];
    end
  end

  typedef struct { logic [63:0] rd; bit chk; int cyc; } exp_t;
  typedef struct { int cyc; logic [31:0] a; logic [3:0] we; logic [31:0] d; } beat_t;
  typedef struct { logic [31:0] addr; logic [7:0] we; logic [63:0] wd; logic [63:0] erd; bit chk; } vec_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit issued(input logic [7:0] w, input int k);
    return !SKIP || (w == 8'h00) || (w[4*k +: 4] != 4'h0);
  endfunction

  function automatic int nbeats(input logic [7:0] w);
    int n = 0;
    for (int k = 0; k < 2; k++) if (issued(w, k)) n++;
    return n;
  endfunction

  always @(negedge clk) begin : mon
    exp_t  e;
    beat_t bb;
    if (rst_n && rsp) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_rsp: got RspValid at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk) check("rd_data", rd, e.rd);
      end
    end
    if (en) begin
      bb.cyc = cyc; bb.a = baddr; bb.we = bwe; bb.d = bwd;
      beat_q.push_back(bb);
    end else if (rst_n) begin
      check("idle_addr", 64'(baddr), 64'h0);
      check("idle_wren", 64'(bwe), 64'h0);
      check("idle_wdata", 64'(bwd), 64'h0);
    end
  end

  task automatic do_txn(input logic [31:0] a, input logic [7:0] w, input logic [63:0] d,
                        input logic [63:0] erd, input bit chk, input bit keep, output int t0);
    int   n = 0;
    exp_t e;
    req = 1'b1; addr = a; we = w; wd = d;
    while (!gnt && n < 50) begin @(negedge clk); n++; end
    t0 = cyc;
    if (!gnt) begin
      checks++; failures++;
      $display("FAIL grant_timeout: got no grant in %0d cycles, expected grant", n);
      req = 1'b0;
      return;
    end
    e.rd = erd; e.chk = chk; e.cyc = cyc + nbeats(w) + 2;
    exp_q.push_back(e);
    @(negedge clk);
    if (!keep) req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin @(negedge clk); n++; end while (exp_q.size() != 0 && n < 50);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: got %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_beats(input logic [31:0] a, input logic [7:0] w, input logic [63:0] d, input int t0);
    int    i = 0;
    beat_t b;
    for (int k = 0; k < 2; k++) begin
      if (issued(w, k)) begin
        if (beat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_missing: got no beat for slice %0d, expected one at cycle %0d", k, t0 + 1 + i);
        end else begin
          b = beat_q.pop_front();
          check("beat_cycle", 64'(b.cyc), 64'(t0 + 1 + i));
          check("beat_addr", 64'(b.a), 64'((a & 32'hFFFF_FFF8) + 32'(4 * k)));
          check("beat_wren", 64'(b.we), 64'(w[4*k +: 4]));
          check("beat_wdata", 64'(b.d), 64'(d[32*k +: 32]));
        end
        i++;
      end
    end
    check("beat_count_extra", 64'(beat_q.size()), 64'h0);
  endtask

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t vecs[8];
    int   t0, a0, a1, a2;

    vecs[0] = '{32'h10, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0};
    vecs[1] = '{32'h10, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b1};
    vecs[2] = '{32'h18, 8'hF0, 64'hAABB_CCDD_0000_0000, 64'h0, 1'b0};
    vecs[3] = '{32'h1D, 8'h00, 64'h0, 64'hAABB_CCDD_0000_0000, 1'b1};
    vecs[4] = '{32'h20, 8'h0F, 64'hFFFF_FFFF_CAFE_F00D, 64'h0, 1'b0};
    vecs[5] = '{32'h20, 8'h3C, 64'hDEAD_BEEF_1234_5678, 64'h0, 1'b0};
    vecs[6] = '{32'h24, 8'h00, 64'h5555_5555_5555_5555, 64'h0000_BEEF_1234_F00D, 1'b1};
    vecs[7] = '{32'h10, 8'h00, 64'h0123_4567_89AB_CDEF, 64'h1122_3344_5566_7788, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'h1);
    check("rst_rsp", 64'(rsp), 64'h0);
    check("rst_rd", rd, 64'h0);
    check("rst_en", 64'(en), 64'h0);
    check("rst_addr", 64'(baddr), 64'h0);
    check("rst_wren", 64'(bwe), 64'h0);
    check("rst_wdata", 64'(bwd), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      beat_q.delete();
      do_txn(vecs[i].addr, vecs[i].we, vecs[i].wd, vecs[i].erd, vecs[i].chk, 1'b0, t0);
      drain();
      check_beats(vecs[i].addr, vecs[i].we, vecs[i].wd, t0);
    end

    // Back-to-back reads with Req held: accepts every 4 cycles.
    beat_q.delete();
    do_txn(32'h10, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b1, 1'b1, a0);
    do_txn(32'h18, 8'h00, 64'h0, 64'hAABB_CCDD_0000_0000, 1'b1, 1'b1, a1);
    do_txn(32'h20, 8'h00, 64'h0, 64'h0000_BEEF_1234_F00D, 1'b1, 1'b0, a2);
    drain();
    check("b2b_gap1", 64'(a1 - a0), 64'd4);
    check("b2b_gap2", 64'(a2 - a1), 64'd4);
    check("b2b_beats", 64'(beat_q.size()), 64'd6);

    // Reset in the middle of a beat: transaction dropped, no response.
    req = 1'b1; addr = 32'h10; we = 8'h00; wd = '0;
    @(negedge clk);
    req = 1'b0;
    check("pre_reset_en", 64'(en), 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_en", 64'(en), 64'h0);
    check("midrst_gnt", 64'(gnt), 64'h1);
    check("midrst_rd", rd, 64'h0);
    check("midrst_rsp", 64'(rsp), 64'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_gnt", 64'(gnt), 64'h1);

    // Normal operation after the aborted access.
    beat_q.delete();
    do_txn(32'h20, 8'h00, 64'h0, 64'h0000_BEEF_1234_F00D, 1'b1, 1'b0, t0);
    drain();
    check_beats(32'h20, 8'h00, 64'h0, t0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_dwc_down.md
Name: bram_dwc_down

Overview:
- Wide-to-narrow BRAM data width converter.
- A wide master issues one access. The block splits it into RATIO sequential narrow BRAM beats, gathers the narrow read data into one wide word, and returns it with a response pulse.
- Sits between wide AXI-side logic (e.g. 64-bit config/TLB access) and narrow 32-bit BRAM macros.
- A request/grant handshake absorbs the multi-cycle latency.

Parameters:
- WIDE_DATA_BITW, 64, master data width; must be a power-of-two multiple of NARROW_DATA_BITW.
- NARROW_DATA_BITW, 32, BRAM data width; multiple of 8.
- ADDR_BITW, 32, byte-address width on both sides.
- Derived constants: RATIO = WIDE_DATA_BITW/NARROW_DATA_BITW; WB = WIDE_DATA_BITW/8; NB = NARROW_DATA_BITW/8.

Ports:
- Clk_C  in  1  clock; all logic on rising edge.
- Rst_RBI  in  1  asynchronous, active-low reset.
- Req_SI  in  1  wide access request.
- Gnt_SO  out  1  request accepted when Req_SI && Gnt_SO at a rising edge.
- Addr_SI  in  ADDR_BITW  wide byte address; low log2(WB) bits ignored.
- WrEn_SI  in  WB  byte write enables; all-zero means read.
- Wr_DI  in  WIDE_DATA_BITW  write data.
- RspValid_SO  out  1  one-cycle completion pulse per accepted request.
- Rd_DO  out  WIDE_DATA_BITW  assembled read data; valid while RspValid_SO is high, held afterwards.
- En_SO  out  1  BRAM enable.
- Addr_SO  out  ADDR_BITW  BRAM byte address.
- WrEn_SO  out  NB  BRAM byte write enables.
- Wr_DO  out  NARROW_DATA_BITW  BRAM write data.
- Rd_DI  in  NARROW_DATA_BITW  BRAM read data, 1-cycle latency after the enabled beat.

Behaviour:
- Reset (async assert, sync-to-clock deassert irrelevant): state IDLE; all registers cleared.
  - Outputs: Gnt_SO=1, RspValid_SO=0, Rd_DO=0, En_SO=0, Addr_SO=0, WrEn_SO=0, Wr_DO=0.
  - Reset mid-transaction aborts it. No response is issued; the beat in flight is simply dropped.
- States:
  - IDLE: Gnt_SO=1. On accept, latch Addr/WrEn/Wr_D, set beat index k=0, go to BEAT.
  - BEAT: En_SO=1; Addr_SO = {Addr_SI[ADDR_BITW-1:log2(WB)], k, log2(NB) zeros}; WrEn_SO = WrEn latch slice k; Wr_DO = data latch slice k.
    - k increments every cycle. After beat k=RATIO-1, go to LAST.
    - From the cycle after beat 0, capture Rd_DI into Rd slice k-1.
  - LAST: En_SO=0, WrEn_SO=0; capture Rd_DI into slice RATIO-1; go to RESP.
  - RESP: RspValid_SO=1; Rd_DO = gathered word; Gnt_SO=1.
    - Accept in RESP goes directly to BEAT (back-to-back); otherwise go to IDLE.
- Gnt_SO is 0 in BEAT and LAST. Req_SI is ignored there and must be held by the master until granted.
- Latency: accept at edge of cycle t0 -> beats in cycles t0+1..t0+RATIO -> RspValid_SO in cycle t0+RATIO+2.
  - Throughput: one transaction per RATIO+2 cycles.
- Slice ordering: slice k = bits [(k+1)*NARROW_DATA_BITW-1 : k*NARROW_DATA_BITW], ascending narrow addresses (little-endian).
- Writes also return RspValid_SO. Rd_DO content after a write equals the BRAM read-during-write data and is don't-care.
- Outputs En_SO, Addr_SO, WrEn_SO, Wr_DO are driven combinationally from state and latches. They are stable for the whole beat cycle and zero outside BEAT.
- RATIO=1 is legal: a single beat, same latency rule (3 cycles).
- Elaboration fatal if WIDE_DATA_BITW < NARROW_DATA_BITW or RATIO is not a power of two.

Optional Feature:
- Macro BRAM_DWC_DOWN_WRSKIP_EN.
- Defined: for write transactions (WrEn latch non-zero), beats whose WrEn slice is all-zero are not issued.
  - The FSM steps directly to the next non-zero slice in ascending order, one issued beat per cycle.
  - After the last issued beat it goes to LAST, then RESP.
  - Rd_DO holds its previous value for writes.
  - Reads are unchanged.
- Undefined: every transaction issues all RATIO beats, as above.

Test Plan:
- Reset: Rst_RBI low mid-BEAT -> next cycle En_SO=0, Gnt_SO=1, Rd_DO=0, no RspValid_SO pulse.
- Write (64/32): Addr 0x10, WrEn 0xFF, data 0x1122334455667788 -> beat t0+1: Addr_SO=0x10, WrEn_SO=0xF, Wr_DO=0x55667788; beat t0+2: Addr_SO=0x14, WrEn_SO=0xF, Wr_DO=0x11223344; RspValid_SO at t0+4.
- Read back: Addr 0x10, WrEn 0 -> two beats with WrEn_SO=0; Rd_DO=0x1122334455667788 with RspValid_SO at t0+4.
- Partial write: WrEn 0xF0 -> beat 0 WrEn_SO=0x0, beat 1 WrEn_SO=0xF.
  - With WRSKIP_EN: only one beat, Addr_SO=0x14; RspValid_SO at t0+3.
- Back-to-back: Req_SI held high for 3 reads -> Gnt_SO pulses in RESP; accepts at t0, t0+4, t0+8; no idle cycle between transactions.
- Unaligned: Addr 0x1D -> Addr_SO beats 0x18, 0x1C.
